// File: rtl/bp_dispatch.sv
// rtl/bp_dispatch.sv - Bus Pirate command dispatcher between the inbound/outbound FIFOs and the IO pin array.
// Optional feature macro: ERROR_RESP_EN (reserved opcodes return an error word).
module bp_dispatch #(
    parameter int FIFO_WIDTH = 16,
    parameter int BP_PINS    = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  in_fifo_out_clock,
    input  logic                  in_fifo_out_nempty,
    output logic                  in_fifo_out_pop,
    input  logic [FIFO_WIDTH-1:0] in_fifo_out_data,
    output logic                  out_fifo_in_clock,
    input  logic                  out_fifo_in_full,
    output logic                  out_fifo_in_shift,
    output logic [FIFO_WIDTH-1:0] out_fifo_in_data,
    output logic [BP_PINS-1:0]    bp_din,
    input  logic [BP_PINS-1:0]    bp_dout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_WRITE = 4'd1;
    localparam logic [3:0] OP_READ  = 4'd2;
    localparam logic [3:0] OP_DELAY = 4'd3;
    localparam logic [3:0] OP_SET   = 4'd4;
    localparam logic [3:0] OP_CLR   = 4'd5;
    localparam logic [3:0] OP_ECHO  = 4'd6;

    state_t                  state;
    state_t                  state_next;
    logic [FIFO_WIDTH-1:0]   cmd;
    logic [11:0]             counter;
    logic [FIFO_WIDTH-1:0]   resp;

    logic [3:0]              opcode;
    logic [11:0]             arg;
    logic [BP_PINS-1:0]      value;

    assign opcode = cmd[15:12];
    assign arg    = cmd[11:0];
    assign value  = cmd[BP_PINS-1:0];

    assign in_fifo_out_clock = clock;
    assign out_fifo_in_clock = clock;
    assign out_fifo_in_data  = resp;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next        = state;
        in_fifo_out_pop   = 1'b0;
        out_fifo_in_shift = 1'b0;
        case (state)
            ST_IDLE: begin
                // Gated by reset so a word is never popped while the core ignores it.
                if (in_fifo_out_nempty && !reset) begin
                    in_fifo_out_pop = 1'b1;
                    state_next      = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_READ, OP_ECHO: state_next = ST_RESP;
                    OP_DELAY:         state_next = (arg == 12'd0) ? ST_IDLE : ST_WAIT;
                    default: begin
`ifdef ERROR_RESP_EN
                        state_next = (opcode > OP_ECHO) ? ST_RESP : ST_IDLE;
`else
                        state_next = ST_IDLE;
`endif
                    end
                endcase
            end
            ST_WAIT: begin
                if (counter <= 12'd1) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (!out_fifo_in_full) begin
                    out_fifo_in_shift = 1'b1;
                    state_next        = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd     <= '0;
            counter <= '0;
            resp    <= '0;
            bp_din  <= '0;
        end else begin
            if (in_fifo_out_pop) begin
                cmd <= in_fifo_out_data;
            end
            if (state == ST_DECODE) begin
                case (opcode)
                    OP_NOP:   ;
                    OP_WRITE: bp_din  <= value;
                    OP_READ:  resp    <= {{(FIFO_WIDTH-BP_PINS){1'b0}}, bp_dout};
                    OP_DELAY: counter <= arg;
                    OP_SET:   bp_din  <= bp_din | value;
                    OP_CLR:   bp_din  <= bp_din & ~value;
                    OP_ECHO:  resp    <= {4'h0, arg};
                    default: begin
`ifdef ERROR_RESP_EN
                        resp <= {4'hE, opcode, 8'h00};
`endif
                    end
                endcase
            end else if (state == ST_WAIT) begin
                counter <= counter - 12'd1;
            end
        end
    end

endmodule

// File: tb/tb_bp_dispatch.sv
// tb/tb_bp_dispatch.sv - directed self-checking bench for bp_dispatch with FIFO models.
module tb_bp_dispatch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_fifo_out_clock;
    logic        in_fifo_out_nempty = 1'b0;
    logic        in_fifo_out_pop;
    logic [15:0] in_fifo_out_data = 16'h0;
    logic        out_fifo_in_clock;
    logic        out_fifo_in_full = 1'b0;
    logic        out_fifo_in_shift;
    logic [15:0] out_fifo_in_data;
    logic [4:0]  bp_din;
    logic [4:0]  bp_dout = 5'h00;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pop_cnt = 0;
    int shift_cnt = 0;
    int both_cnt = 0;
    bit pend_pop = 0;
    logic [15:0] inq[$];
    logic [15:0] outq[$];
    int pop_cyc[$];

    bp_dispatch #(.FIFO_WIDTH(16), .BP_PINS(5)) dut (
        .clock              (clock),
        .reset              (reset),
        .in_fifo_out_clock  (in_fifo_out_clock),
        .in_fifo_out_nempty (in_fifo_out_nempty),
        .in_fifo_out_pop    (in_fifo_out_pop),
        .in_fifo_out_data   (in_fifo_out_data),
        .out_fifo_in_clock  (out_fifo_in_clock),
        .out_fifo_in_full   (out_fifo_in_full),
        .out_fifo_in_shift  (out_fifo_in_shift),
        .out_fifo_in_data   (out_fifo_in_data),
        .bp_din             (bp_din),
        .bp_dout            (bp_dout)
    );

    always #5 clock = ~clock;

    // Strobes are observed on the falling edge, where combinational outputs are settled.
    always @(negedge clock) begin
        if (in_fifo_out_pop) begin
            pop_cnt++;
            pop_cyc.push_back(cyc);
            pend_pop = 1;
        end
        if (out_fifo_in_shift) begin
            shift_cnt++;
            outq.push_back(out_fifo_in_data);
        end
        if (in_fifo_out_pop && out_fifo_in_shift) both_cnt++;
    end

    // Show-ahead inbound FIFO model, updated just after each rising edge.
    always @(posedge clock) begin
        #1;
        cyc++;
        if (pend_pop) begin
            if (inq.size() != 0) void'(inq.pop_front());
            pend_pop = 0;
        end
        in_fifo_out_nempty = (inq.size() != 0);
        in_fifo_out_data   = (inq.size() != 0) ? inq[0] : 16'h0000;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic wait_pop(output bit ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (in_fifo_out_pop) begin
                ok = 1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(2);
        @(negedge clock);
        tests++; if (bp_din !== 5'h00) begin fails++; $display("FAIL reset_bp_din got %h want 00", bp_din); end
        tests++; if (in_fifo_out_pop !== 1'b0) begin fails++; $display("FAIL reset_pop got %b want 0", in_fifo_out_pop); end
        tests++; if (out_fifo_in_shift !== 1'b0) begin fails++; $display("FAIL reset_shift got %b want 0", out_fifo_in_shift); end
        tests++; if (out_fifo_in_data !== 16'h0000) begin fails++; $display("FAIL reset_data got %h want 0000", out_fifo_in_data); end
    endtask

    task automatic test_write();
        int s0;
        bit ok;
        s0 = shift_cnt;
        inq.push_back(16'h1015);
        wait_pop(ok);
        tests++; if (!ok) begin fails++; $display("FAIL write_pop_timeout got none want pop"); end
        @(negedge clock);
        tests++; if (in_fifo_out_pop !== 1'b0) begin fails++; $display("FAIL write_pop_pulse got %b want 0", in_fifo_out_pop); end
        tests++; if (bp_din !== 5'h00) begin fails++; $display("FAIL write_early got %h want 00", bp_din); end
        @(negedge clock);
        tests++; if (bp_din !== 5'h15) begin fails++; $display("FAIL write_bp_din got %h want 15", bp_din); end
        wait_cycles(3);
        tests++; if (shift_cnt != s0) begin fails++; $display("FAIL write_no_shift got %0d want %0d", shift_cnt, s0); end
    endtask

    task automatic test_read();
        int s0;
        s0 = shift_cnt;
        outq.delete();
        bp_dout = 5'h0A;
        inq.push_back(16'h2000);
        wait_cycles(10);
        tests++; if (shift_cnt - s0 != 1) begin fails++; $display("FAIL read_shift_count got %0d want 1", shift_cnt - s0); end
        tests++; if (outq.size() == 0 || outq[0] !== 16'h000A) begin fails++; $display("FAIL read_data got %h want 000a", (outq.size() != 0) ? outq[0] : 16'hxxxx); end
        bp_dout = 5'h00;
    endtask

    task automatic test_full();
        int s0, p0;
        s0 = shift_cnt;
        p0 = pop_cnt;
        outq.delete();
        out_fifo_in_full = 1'b1;
        inq.push_back(16'h6ABC);
        inq.push_back(16'h1003);
        wait_cycles(10);
        @(negedge clock);
        tests++; if (out_fifo_in_shift !== 1'b0) begin fails++; $display("FAIL full_shift got %b want 0", out_fifo_in_shift); end
        tests++; if (shift_cnt != s0) begin fails++; $display("FAIL full_no_shift got %0d want %0d", shift_cnt, s0); end
        tests++; if (pop_cnt - p0 != 1) begin fails++; $display("FAIL full_pops got %0d want 1", pop_cnt - p0); end
        tests++; if (out_fifo_in_data !== 16'h0ABC) begin fails++; $display("FAIL full_hold_data got %h want 0abc", out_fifo_in_data); end
        tests++; if (bp_din !== 5'h15) begin fails++; $display("FAIL full_bp_din_held got %h want 15", bp_din); end
        wait_cycles(1);
        out_fifo_in_full = 1'b0;
        wait_cycles(10);
        tests++; if (shift_cnt - s0 != 1) begin fails++; $display("FAIL release_shift got %0d want 1", shift_cnt - s0); end
        tests++; if (outq.size() == 0 || outq[0] !== 16'h0ABC) begin fails++; $display("FAIL release_data got %h want 0abc", (outq.size() != 0) ? outq[0] : 16'hxxxx); end
        tests++; if (pop_cnt - p0 != 2) begin fails++; $display("FAIL release_pops got %0d want 2", pop_cnt - p0); end
        tests++; if (bp_din !== 5'h03) begin fails++; $display("FAIL release_next_cmd got %h want 03", bp_din); end
    endtask

    task automatic test_set_clr();
        inq.push_back(16'h1011);
        wait_cycles(6);
        inq.push_back(16'h4006);
        wait_cycles(6);
        tests++; if (bp_din !== 5'h17) begin fails++; $display("FAIL set got %h want 17", bp_din); end
        inq.push_back(16'h5001);
        wait_cycles(6);
        tests++; if (bp_din !== 5'h16) begin fails++; $display("FAIL clr got %h want 16", bp_din); end
        inq.push_back(16'h1FF5);
        wait_cycles(6);
        tests++; if (bp_din !== 5'h15) begin fails++; $display("FAIL write_high_bits got %h want 15", bp_din); end
    endtask

    task automatic test_delay();
        int n;
        n = pop_cyc.size();
        inq.push_back(16'h1001);
        inq.push_back(16'h1002);
        wait_cycles(12);
        tests++; if (pop_cyc.size() < n + 2 || pop_cyc[n+1] - pop_cyc[n] != 2) begin fails++; $display("FAIL back_to_back_gap got %0d want 2", (pop_cyc.size() >= n + 2) ? pop_cyc[n+1] - pop_cyc[n] : -1); end
        n = pop_cyc.size();
        inq.push_back(16'h3005);
        inq.push_back(16'h1001);
        wait_cycles(14);
        tests++; if (pop_cyc.size() < n + 2 || pop_cyc[n+1] - pop_cyc[n] != 7) begin fails++; $display("FAIL delay5_gap got %0d want 7", (pop_cyc.size() >= n + 2) ? pop_cyc[n+1] - pop_cyc[n] : -1); end
        n = pop_cyc.size();
        inq.push_back(16'h3000);
        inq.push_back(16'h1004);
        wait_cycles(12);
        tests++; if (pop_cyc.size() < n + 2 || pop_cyc[n+1] - pop_cyc[n] != 2) begin fails++; $display("FAIL delay0_gap got %0d want 2", (pop_cyc.size() >= n + 2) ? pop_cyc[n+1] - pop_cyc[n] : -1); end
        tests++; if (bp_din !== 5'h04) begin fails++; $display("FAIL delay_followup got %h want 04", bp_din); end
    endtask

    task automatic test_reserved();
        int s0;
        s0 = shift_cnt;
        outq.delete();
        inq.push_back(16'h9000);
        wait_cycles(10);
`ifdef ERROR_RESP_EN
        tests++; if (shift_cnt - s0 != 1) begin fails++; $display("FAIL reserved_shift got %0d want 1", shift_cnt - s0); end
        tests++; if (outq.size() == 0 || outq[0] !== 16'hE900) begin fails++; $display("FAIL reserved_word got %h want e900", (outq.size() != 0) ? outq[0] : 16'hxxxx); end
`else
        tests++; if (shift_cnt != s0) begin fails++; $display("FAIL reserved_no_shift got %0d want %0d", shift_cnt, s0); end
`endif
        tests++; if (bp_din !== 5'h04) begin fails++; $display("FAIL reserved_bp_din got %h want 04", bp_din); end
    endtask

    task automatic test_reset_mid();
        int p0;
        bit ok;
        p0 = pop_cnt;
        inq.push_back(16'h3FFF);
        inq.push_back(16'h1007);
        wait_pop(ok);
        tests++; if (!ok) begin fails++; $display("FAIL midreset_pop_timeout got none want pop"); end
        wait_cycles(6);
        reset = 1'b1;
        @(negedge clock);
        tests++; if (bp_din !== 5'h00) begin fails++; $display("FAIL midreset_bp_din got %h want 00", bp_din); end
        tests++; if (in_fifo_out_pop !== 1'b0) begin fails++; $display("FAIL midreset_pop got %b want 0", in_fifo_out_pop); end
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(8);
        tests++; if (pop_cnt - p0 != 2) begin fails++; $display("FAIL midreset_pops got %0d want 2", pop_cnt - p0); end
        tests++; if (bp_din !== 5'h07) begin fails++; $display("FAIL midreset_next_cmd got %h want 07", bp_din); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_full();
        test_set_clr();
        test_delay();
        test_reserved();
        test_reset_mid();
        tests++; if (both_cnt != 0) begin fails++; $display("FAIL pop_shift_overlap got %0d want 0", both_cnt); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
